// File: rtl/fb_pixel_gen.sv
// Frame-buffer pixel generator: fills a per-pixel iteration-count RAM from a
// pattern, a clear, or an external stream, and reads it out in raster order through a palette.
module fb_pixel_gen #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int DATA_W    = 7,
  parameter int ADDR_W    = 19,
  parameter bit AUTO_FILL = 1'b1
) (
  input  logic              CLK_100MHz,
  input  logic              reset,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic [1:0]        palette_sel,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic [11:0]       color
);

  // state   | meaning
  // IDLE    | no fill running, waiting for start (or the post-reset auto fill)
  // PATTERN | writing addr mod 2^DATA_W, one address per cycle
  // CLEAR   | writing zero, one address per cycle
  // EXT     | writing wr_data on each valid/ready handshake
  typedef enum logic [1:0] {S_IDLE, S_PATTERN, S_CLEAR, S_EXT} state_t;

  localparam int N = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                done_q, done_d;
  logic                auto_q;
  logic                we;
  logic [DATA_W-1:0]   wdata;

  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_blank;
  logic [ADDR_W-1:0]   s0_addr_q;
  logic                s0_blank_q;
  logic [1:0]          s0_pal_q;
  logic [DATA_W-1:0]   s1_data_q;
  logic                s1_blank_q;
  logic [1:0]          s1_pal_q;
  logic [11:0]         pal_color;
  logic [11:0]         color_q;
  logic [3:0]          msb4;
  logic [7:0]          direct8;

  always_ff @(posedge CLK_100MHz) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      done_q  <= 1'b0;
      auto_q  <= AUTO_FILL;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      auto_q  <= 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    done_d   = 1'b0;
    we       = 1'b0;
    wdata    = '0;
    wr_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (auto_q) begin
          state_d = S_PATTERN;
        end else if (start) begin
          case (mode)
            2'd0:    state_d = S_EXT;
            2'd1:    state_d = S_PATTERN;
            2'd2:    state_d = S_CLEAR;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_PATTERN: begin
        we    = 1'b1;
        wdata = DATA_W'(addr_q);
      end
      S_CLEAR: begin
        we    = 1'b1;
        wdata = '0;
      end
      S_EXT: begin
        wr_ready = 1'b1;
        we       = wr_valid;
        wdata    = wr_data;
      end
      default: state_d = S_IDLE;
    endcase
    if (we) begin
      if (addr_q == LAST_ADDR) begin
        state_d = S_IDLE;
        addr_d  = '0;
        done_d  = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

  // Read-first dual-port RAM; writes are suppressed while reset is held.
  always_ff @(posedge CLK_100MHz) begin
    if (we && reset) mem[addr_q] <= wdata;
    s1_data_q <= mem[s0_addr_q];
  end

  always_comb begin
    rd_addr  = ADDR_W'(pixel_y) * ADDR_W'(H_RES) + ADDR_W'(pixel_x);
    rd_blank = !video_on || (32'(pixel_x) >= 32'(H_RES)) || (32'(pixel_y) >= 32'(V_RES));
  end

  always_ff @(posedge CLK_100MHz) begin
    if (!reset) begin
      s0_addr_q  <= '0;
      s0_blank_q <= 1'b1;
      s0_pal_q   <= '0;
      s1_blank_q <= 1'b1;
      s1_pal_q   <= '0;
      color_q    <= '0;
    end else begin
      s0_addr_q  <= rd_addr;
      s0_blank_q <= rd_blank;
      s0_pal_q   <= palette_sel;
      s1_blank_q <= s0_blank_q;
      s1_pal_q   <= s0_pal_q;
      color_q    <= s1_blank_q ? 12'h000 : pal_color;
    end
  end

  always_comb begin
    msb4    = s1_data_q[DATA_W-1 -: 4];
    direct8 = 8'(s1_data_q);
    case (s1_pal_q)
      2'd0:    pal_color = {4'h0, direct8};
      2'd1:    pal_color = {msb4, msb4, msb4};
      2'd2:    pal_color = (s1_data_q == {DATA_W{1'b1}}) ? 12'h000 : {msb4, ~msb4, 4'h0};
      default: pal_color = ~{msb4, msb4, msb4};
    endcase
  end

  assign color = color_q;

endmodule

// File: tb/tb_fb_pixel_gen.sv
// Bench for fb_pixel_gen on an 8x4 frame: behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fb_pixel_gen;

  logic        clk;
  logic        reset;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [1:0]  mode;
  logic        start;
  logic [1:0]  palette_sel;
  logic        wr_valid;
  logic [6:0]  wr_data;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic [11:0] color;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  fb_pixel_gen #(
    .H_RES(8), .V_RES(4), .DATA_W(7), .ADDR_W(5), .AUTO_FILL(1'b1)
  ) dut (
    .CLK_100MHz(clk), .reset(reset), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .mode(mode), .start(start),
    .palette_sel(palette_sel), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .done(done), .color(color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] pal_fn(input logic [6:0] d, input logic [1:0] p);
    logic [3:0] m;
    m = d[6:3];
    case (p)
      2'd0:    return {4'h0, 1'b0, d};
      2'd1:    return {m, m, m};
      2'd2:    return (d == 7'd127) ? 12'h000 : {m, ~m, 4'h0};
      default: return ~{m, m, m};
    endcase
  endfunction

  // Model: fill kind 0 none, 1 pattern, 2 clear, 3 ext; 3-register read pipeline.
  int          m_kind, m_addr;
  bit          m_auto;
  logic [6:0]  mem_m [32];
  int          p0_addr;
  bit          p0_blank, p1_blank;
  logic [1:0]  p0_pal, p1_pal;
  logic [6:0]  p1_data;
  logic [11:0] e_color;
  bit          e_done;

  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_kind = 0; m_addr = 0; m_auto = 1; e_done = 0;
        p0_blank = 1; p1_blank = 1; e_color = 12'h000;
      end else begin
        bit wrote, was_idle;
        e_color  = p1_blank ? 12'h000 : pal_fn(p1_data, p1_pal);
        p1_data  = mem_m[p0_addr];
        p1_blank = p0_blank;
        p1_pal   = p0_pal;
        p0_addr  = (int'(pixel_y) * 8 + int'(pixel_x)) % 32;
        p0_blank = !video_on || pixel_x >= 8 || pixel_y >= 4;
        p0_pal   = palette_sel;
        was_idle = (m_kind == 0);
        wrote    = 0;
        e_done   = 0;
        if (m_kind == 1) begin mem_m[m_addr] = 7'(m_addr % 128); wrote = 1; end
        if (m_kind == 2) begin mem_m[m_addr] = 7'd0; wrote = 1; end
        if (m_kind == 3 && wr_valid) begin mem_m[m_addr] = wr_data; wrote = 1; end
        if (wrote) begin
          if (m_addr == 31) begin m_kind = 0; m_addr = 0; e_done = 1; end
          else m_addr++;
        end
        if (was_idle) begin
          if (m_auto) m_kind = 1;
          else if (start && mode == 2'd0) m_kind = 3;
          else if (start && mode == 2'd1) m_kind = 1;
          else if (start && mode == 2'd2) m_kind = 2;
        end
        m_auto = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc color", 32'(color), 32'(e_color));
        chk("cyc busy", 32'(busy), 32'(m_kind != 0));
        chk("cyc done", 32'(done), 32'(e_done));
        chk("cyc wr_ready", 32'(wr_ready), 32'(m_kind == 3));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_fill(input int n, output int bc, output int dc);
    bc = 0; dc = 0;
    for (int k = 0; k < n; k++) begin
      if (busy) bc++;
      if (done) dc++;
      tick();
    end
  endtask

  task automatic read_px(input int x, input int y, input bit vo, input logic [1:0] p,
                         output logic [11:0] c);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = vo; palette_sel = p;
    tick(); tick(); tick();
    c = color;
    video_on = 0;
  endtask

  initial begin
    int bc, dc, hs, cyc;
    bit fire;
    logic [11:0] c;
    reset = 0; video_on = 0; pixel_x = 0; pixel_y = 0; mode = 0; start = 0;
    palette_sel = 0; wr_valid = 0; wr_data = 0;

    tick(); chk_en = 1; tick(); tick();
    chk("reset color", 32'(color), 32'h000);
    chk("reset busy", 32'(busy), 0);
    chk("reset wr_ready", 32'(wr_ready), 0);
    chk("reset done", 32'(done), 0);

    reset = 1; tick();
    count_fill(40, bc, dc);
    chk("auto busy cycles", bc, 32);
    chk("auto done pulses", dc, 1);

    // Raster sweep with palette changing per pixel.
    video_on = 1;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++) begin
        pixel_x = 10'(x); pixel_y = 10'(y); palette_sel = 2'((x + y) % 4);
        tick();
      end
    video_on = 0; tick(); tick(); tick();

    read_px(5, 2, 1, 2'd0, c); chk("direct addr21", 32'(c), 32'h015);
    read_px(5, 2, 1, 2'd1, c); chk("gray addr21", 32'(c), 32'h222);
    read_px(5, 2, 1, 2'd2, c); chk("heat addr21", 32'(c), 32'h2D0);
    read_px(5, 2, 1, 2'd3, c); chk("invgray addr21", 32'(c), 32'hDDD);
    read_px(5, 2, 0, 2'd1, c); chk("video_off blank", 32'(c), 32'h000);
    read_px(9, 2, 1, 2'd1, c); chk("x range blank", 32'(c), 32'h000);
    read_px(7, 3, 1, 2'd0, c); chk("direct addr31", 32'(c), 32'h01F);

    // EXT fill with random stalls.
    chk("ext ready before start", 32'(wr_ready), 0);
    mode = 0; start = 1; tick(); start = 0;
    chk("ext wr_ready rise", 32'(wr_ready), 1);
    hs = 0; cyc = 0;
    while (hs < 32 && cyc < 500) begin
      wr_valid = ($urandom_range(0, 2) != 0);
      wr_data  = 7'(127 - hs);
      fire     = wr_valid && wr_ready;
      tick(); cyc++;
      if (fire) hs++;
    end
    wr_valid = 0;
    chk("ext handshakes", hs, 32);
    chk("ext done after last", 32'(done), 1);
    chk("ext busy after last", 32'(busy), 0);
    chk("ext wr_ready fall", 32'(wr_ready), 0);
    tick();
    chk("ext done single", 32'(done), 0);
    read_px(0, 0, 1, 2'd2, c); chk("heat in-set addr0", 32'(c), 32'h000);
    read_px(1, 0, 1, 2'd2, c); chk("heat addr1", 32'(c), 32'hF00);
    read_px(0, 0, 1, 2'd0, c); chk("direct addr0 ext", 32'(c), 32'h07F);

    // CLEAR with an ignored mid-fill start.
    mode = 2; start = 1; tick(); start = 0;
    bc = 0; dc = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 10) begin start = 1; mode = 1; end else start = 0;
      if (busy) bc++;
      if (done) dc++;
      tick();
    end
    start = 0;
    chk("clear busy cycles", bc, 32);
    chk("clear done pulses", dc, 1);

    // mode 3 start is ignored.
    mode = 3; start = 1; tick(); start = 0;
    chk("mode3 busy", 32'(busy), 0);
    count_fill(6, bc, dc);
    chk("mode3 no busy", bc, 0);
    chk("mode3 no done", dc, 0);

    // Reset in the middle of EXT.
    mode = 0; start = 1; tick(); start = 0; wr_valid = 1;
    for (int i = 0; i < 10; i++) begin wr_data = 7'(i); tick(); end
    reset = 0; wr_data = 7'd10; tick();
    wr_valid = 0;
    chk("midrst busy", 32'(busy), 0);
    chk("midrst wr_ready", 32'(wr_ready), 0);
    chk("midrst done", 32'(done), 0);
    chk("midrst color", 32'(color), 32'h000);
    tick(); reset = 1; tick();
    count_fill(40, bc, dc);
    chk("refill busy cycles", bc, 32);
    chk("refill done pulses", dc, 1);

    // CLEAR collides with a read of address 3 (holds 3 from the pattern).
    mode = 2; start = 1; tick(); start = 0; tick(); tick();
    pixel_x = 3; pixel_y = 0; video_on = 1; palette_sel = 0;
    tick(); tick(); tick();
    chk("collision old data", 32'(color), 32'h003);
    video_on = 0;
    count_fill(40, bc, dc);
    chk("collision clear busy rest", bc, 27);
    chk("collision clear done", dc, 1);
    read_px(3, 0, 1, 2'd0, c); chk("cleared addr3", 32'(c), 32'h000);
    read_px(7, 3, 1, 2'd3, c); chk("cleared addr31 inv", 32'(c), 32'hFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
